// File: rtl/hazard_stall_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard-detection inputs
// from ID/EX/MEM and the sequencing controls returned to the pipeline registers.
interface hazard_stall_if;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_uses_rt;
    logic [4:0] ID_EX_rt;
    logic       ID_EX_mem_read;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ready;

    logic       pc_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_bubble;
    logic       pipe_freeze;
    logic       mem_timeout;

    // Pipeline datapath side: presents hazard status, consumes sequencing controls.
    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_rt, ID_EX_mem_read,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               mem_timeout
    );

    // Controller side.
    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_rt, ID_EX_mem_read,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stall, taken-branch
// flush and data-memory wait handling, with a sticky timeout and a stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_stall_if.slave    hz,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int FL_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY + 1) : 1;
    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t            state_reg, state_next;
    state_t            ret_state_reg, ret_state_next;
    logic [FL_W-1:0]   flush_left_reg, flush_left_next;
    logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic   load_use;
    logic   dmem_stall;
    logic   act_en;
    state_t act_state;
    logic   pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, pipe_freeze_c;

    assign load_use = hz.ID_EX_mem_read && (hz.ID_EX_rt != 5'd0) &&
                      ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                       (hz.IF_ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));

    // A ready strobe without a request is meaningless and must never stall.
    assign dmem_stall = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        state_next       = state_reg;
        ret_state_next   = ret_state_reg;
        flush_left_next  = flush_left_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        pc_write_c       = 1'b1;
        if_id_write_c    = 1'b1;
        if_id_flush_c    = 1'b0;
        id_ex_bubble_c   = 1'b0;
        pipe_freeze_c    = 1'b0;
        act_en           = 1'b0;
        act_state        = ST_RUN;

        case (state_reg)
            ST_RUN, ST_FLUSH: begin
                act_en    = 1'b1;
                act_state = state_reg;
            end
            ST_MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    // EX is frozen and re-presents branch/load-use once memory completes.
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    pipe_freeze_c = 1'b1;
                    if (int'(wait_cnt_reg) + 1 >= MEM_TIMEOUT) begin
                        state_next       = ST_ERROR;
                        mem_timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    // Completion cycle behaves exactly like the state we stalled out of.
                    wait_cnt_next = '0;
                    act_en        = 1'b1;
                    act_state     = ret_state_reg;
                end
            end
            ST_ERROR: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                pipe_freeze_c = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (act_en) begin
            if (dmem_stall) begin
                // Memory stall outranks everything; flush_left is preserved for the return.
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                pipe_freeze_c  = 1'b1;
                ret_state_next = act_state;
                if (MEM_TIMEOUT <= 1) begin
                    state_next       = ST_ERROR;
                    mem_timeout_next = 1'b1;
                end else begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WC_W'(1);
                end
            end else if (act_state == ST_FLUSH) begin
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
                if (flush_left_reg <= FL_W'(1)) begin
                    state_next      = ST_RUN;
                    flush_left_next = '0;
                end else begin
                    state_next      = ST_FLUSH;
                    flush_left_next = flush_left_reg - 1'b1;
                end
            end else begin
                state_next = ST_RUN;
                if (hz.branch_taken) begin
                    // pc_write stays high so the branch target is loaded this cycle.
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_next      = ST_FLUSH;
                        flush_left_next = FL_W'(BRANCH_PENALTY - 1);
                    end
                end else if (load_use) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            ret_state_reg   <= ST_RUN;
            flush_left_reg  <= '0;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ret_state_reg   <= ret_state_next;
            flush_left_reg  <= flush_left_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!pc_write_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // While reset is asserted the pipeline is held with IF/ID and ID/EX cleared.
    assign hz.pc_write     = rst_n & pc_write_c;
    assign hz.IF_ID_write  = rst_n & if_id_write_c;
    assign hz.IF_ID_flush  = ~rst_n | if_id_flush_c;
    assign hz.ID_EX_bubble = ~rst_n | id_ex_bubble_c;
    assign hz.pipe_freeze  = rst_n & pipe_freeze_c;
    assign hz.mem_timeout  = mem_timeout_reg;
    assign stall_cycles    = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (BRANCH_PENALTY=2, MEM_TIMEOUT=4):
// each cycle's expected controls are queued when driven and compared mid-cycle.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_if hz();

    hazard_stall_ctrl #(
        .BRANCH_PENALTY(2),
        .MEM_TIMEOUT   (4),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (hz),
        .stall_cycles(stall_cycles)
    );

    // ctrl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, mem_timeout}
    localparam logic [5:0] RUNV = 6'b110000;
    localparam logic [5:0] RSTV = 6'b001100;
    localparam logic [5:0] LUV  = 6'b000100;
    localparam logic [5:0] BRV  = 6'b111100;
    localparam logic [5:0] FRZ  = 6'b000010;
    localparam logic [5:0] ERR  = 6'b000011;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [15:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_stall = 0;
    int   cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses_rt, input logic [4:0] ex_rt, input logic mr,
                         input logic br, input logic req, input logic rdy,
                         input logic [5:0] exp_ctrl, input string tag);
        exp_t       e;
        logic [5:0] got;
        rst_n             = rst;
        hz.IF_ID_rs       = rs;
        hz.IF_ID_rt       = rt;
        hz.IF_ID_uses_rt  = uses_rt;
        hz.ID_EX_rt       = ex_rt;
        hz.ID_EX_mem_read = mr;
        hz.branch_taken   = br;
        hz.dmem_req       = req;
        hz.dmem_ready     = rdy;
        if (!rst) exp_stall = 0;
        sb_q.push_back(exp_t'{ctrl: exp_ctrl, stall: exp_stall[15:0]});
        if (rst && !exp_ctrl[5]) exp_stall++;

        @(negedge clk);
        e   = sb_q.pop_front();
        got = {hz.pc_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_bubble,
               hz.pipe_freeze, hz.mem_timeout};
        check_val({tag, ".ctrl"}, {26'd0, got}, {26'd0, e.ctrl});
        check_val({tag, ".stall"}, {16'd0, stall_cycles}, {16'd0, e.stall});
        $display("cyc %0d %-12s ctrl=%b exp=%b stall=%0d exp=%0d",
                 cyc, tag, got, e.ctrl, stall_cycles, e.stall);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst  rs  rt uses ex mr br req rdy
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV, "rst0");
        drive(0, 8, 8, 1, 8, 1, 1, 1, 0, RSTV, "rst_busy");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "idle");

        // Load-use through rs, then the bubble has cleared mem_read
        drive(1, 8, 0, 0, 8, 1, 0, 0, 0, LUV,  "lu_rs");
        drive(1, 8, 0, 0, 8, 0, 0, 0, 0, RUNV, "lu_after");
        // Destination r0 and unused rt never stall
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, RUNV, "lu_r0");
        drive(1, 3, 8, 0, 8, 1, 0, 0, 0, RUNV, "lu_nouse");
        drive(1, 3, 8, 1, 8, 1, 0, 0, 0, LUV,  "lu_rt");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "lu_rt_done");

        // Branch with simultaneous load-use: two flush cycles, pc_write held high
        drive(1, 8, 0, 0, 8, 1, 1, 0, 0, BRV,  "br_lu");
        drive(1, 8, 0, 0, 8, 1, 0, 0, 0, BRV,  "flush2");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "br_done");

        // Three wait cycles; branch and load-use ignored while frozen
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "mw1");
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  "mw2_br");
        drive(1, 8, 0, 0, 8, 1, 0, 1, 0, FRZ,  "mw3_lu");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, "mw_done");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "mw_idle");

        // Memory stall inside a flush: flush resumes once memory is ready
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, BRV,  "br2");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "fl_mw");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, BRV,  "fl_resume");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "fl_done");

        // Ready without request is not a stall
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, RUNV, "rdy_only");

        // Timeout: four wait cycles, then sticky ERROR
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "to1");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "to2");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "to3");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "to4");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, ERR,  "err1");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, ERR,  "err_rdy");
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, ERR,  "err_br");

        // Reset out of ERROR, then a reset pulse in the middle of a wait
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV, "rst_err");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "post_rst");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "mw_a");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "mw_b");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, RSTV, "rst_mid");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "post_rst2");
        drive(1, 8, 0, 0, 8, 1, 0, 0, 0, LUV,  "lu_final");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
